// File: rtl/serial_adder_unit_pkg.sv
// Shared definitions for the serial adder unit: opcode constants, the FSM
// state encoding and the carry-seed helper. Imported by the RTL and the bench.
package serial_adder_unit_pkg;

    // Operation select values
    localparam logic [1:0] OP_ADD  = 2'b00;  // R = A + B
    localparam logic [1:0] OP_SUB  = 2'b01;  // R = A + ~B + 1
    localparam logic [1:0] OP_ADD3 = 2'b10;  // R = A + B + C
    localparam logic [1:0] OP_ADDC = 2'b11;  // R = A + B + C[0]

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Carry seed for the LSB slice: the +1 of two's-complement subtraction,
    // or C[0] as a carry-in, otherwise zero.
    function automatic logic [1:0] init_carry(input logic [1:0] op, input logic c0);
        case (op)
            OP_SUB:  init_carry = 2'd1;
            OP_ADDC: init_carry = {1'b0, c0};
            default: init_carry = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/serial_adder_unit_if.sv
// Operand/result bus of the serial adder unit.
//   in_valid/in_ready   : operand handshake (A, B, C, opcode)
//   out_valid/out_ready : result handshake (R, C_out)
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both 1; the producer keeps its payload stable while
// valid is 1 and ready is 0, and ready never depends combinationally on valid.
// master = the side offering operands and taking results; slave = the unit.
interface serial_adder_unit_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [1:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] R;
    logic             C_out;

    modport master (
        output in_valid, A, B, C, opcode, out_ready,
        input  in_ready, out_valid, R, C_out
    );

    modport slave (
        input  in_valid, A, B, C, opcode, out_ready,
        output in_ready, out_valid, R, C_out
    );
endinterface

// File: rtl/serial_adder_unit_digit_adder.sv
// digit_adder: combinational DIGIT-bit slice adder.
//   a, b, c   : operand slices
//   carry_in  : 2-bit carry (0..2) from the previous slice
//   sum       : DIGIT result bits
//   carry_out : 2-bit carry into the next slice
// The largest total is 3*(2^DIGIT-1)+2 < 3*2^DIGIT, so carry_out never exceeds 2.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic [DIGIT-1:0] c,
    input  logic [1:0]       carry_in,
    output logic [DIGIT-1:0] sum,
    output logic [1:0]       carry_out
);
    localparam int TW = DIGIT + 2;

    logic [TW-1:0] total;

    assign total     = TW'(a) + TW'(b) + TW'(c) + TW'(carry_in);
    assign sum       = total[DIGIT-1:0];
    assign carry_out = total[DIGIT+1:DIGIT];
endmodule

// File: rtl/serial_adder_unit.sv
// serial_adder_unit: digit-serial adder/subtractor. Operands are captured on
// acceptance and processed DIGIT bits per cycle, LSB slice first, over
// N = WIDTH/DIGIT cycles; the result is then held until the consumer takes it.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : operand/result handshake bus (slave side)
//   dbg_state : current FSM state for observation
module serial_adder_unit
    import serial_adder_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_adder_unit_if.slave   bus,
    output state_t               dbg_state
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder_unit: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, c_sh;
    logic [WIDTH-1:0] r_sh;
    logic [1:0]       carry;
    logic [CNT_W-1:0] cnt;
    logic             c_out_q;
    logic             last_slice;

    logic [DIGIT-1:0]       slice_sum;
    logic [1:0]             slice_carry;
    logic [WIDTH+DIGIT-1:0] r_cat;

    assign last_slice = (cnt == CNT_W'(N - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.in_valid)  state_next = ST_RUN;
            ST_RUN:  if (last_slice)    state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.R         = r_sh;
    assign bus.C_out     = c_out_q;
    assign dbg_state     = state;

    // ---------------- datapath ----------------
    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .a         (a_sh[DIGIT-1:0]),
        .b         (b_sh[DIGIT-1:0]),
        .c         (c_sh[DIGIT-1:0]),
        .carry_in  (carry),
        .sum       (slice_sum),
        .carry_out (slice_carry)
    );

    // New slice enters at the top; after N shifts the LSB slice sits at bit 0.
    // Concatenation keeps this legal when DIGIT == WIDTH.
    assign r_cat = {slice_sum, r_sh};

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            c_sh    <= '0;
            r_sh    <= '0;
            carry   <= '0;
            cnt     <= '0;
            c_out_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        // Operand conditioning is done once at capture: B is
                        // inverted for subtraction, C only participates as a
                        // full operand for the three-way add.
                        a_sh  <= bus.A;
                        b_sh  <= (bus.opcode == OP_SUB)  ? ~bus.B : bus.B;
                        c_sh  <= (bus.opcode == OP_ADD3) ? bus.C  : '0;
                        carry <= init_carry(bus.opcode, bus.C[0]);
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    c_sh  <= c_sh >> DIGIT;
                    r_sh  <= r_cat[WIDTH+DIGIT-1:DIGIT];
                    carry <= slice_carry;
                    cnt   <= cnt + CNT_W'(1);
                    // Any residual carry (1 or 2) means the true sum overflowed.
                    if (last_slice) c_out_q <= |slice_carry;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_unit.sv
module tb_serial_adder_unit;
  import serial_adder_unit_pkg::*;

  localparam int W = 8;
  localparam int NS[2] = '{8, 2};  // slices per op for DIGIT=1 and DIGIT=4

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- per-DUT signals (index 0: DIGIT=1, index 1: DIGIT=4) ----------------
  logic         in_valid[2];
  logic         out_ready[2];
  logic [W-1:0] A[2], B[2], C[2];
  logic [1:0]   opcode[2];
  logic         in_ready[2], out_valid[2];
  logic [W-1:0] R[2];
  logic         C_out[2];
  state_t       dbg_d1, dbg_d4;

  serial_adder_unit_if #(.WIDTH(W)) if_d1 ();
  serial_adder_unit_if #(.WIDTH(W)) if_d4 ();

  assign if_d1.in_valid  = in_valid[0];
  assign if_d1.A         = A[0];
  assign if_d1.B         = B[0];
  assign if_d1.C         = C[0];
  assign if_d1.opcode    = opcode[0];
  assign if_d1.out_ready = out_ready[0];
  assign in_ready[0]     = if_d1.in_ready;
  assign out_valid[0]    = if_d1.out_valid;
  assign R[0]            = if_d1.R;
  assign C_out[0]        = if_d1.C_out;

  assign if_d4.in_valid  = in_valid[1];
  assign if_d4.A         = A[1];
  assign if_d4.B         = B[1];
  assign if_d4.C         = C[1];
  assign if_d4.opcode    = opcode[1];
  assign if_d4.out_ready = out_ready[1];
  assign in_ready[1]     = if_d4.in_ready;
  assign out_valid[1]    = if_d4.out_valid;
  assign R[1]            = if_d4.R;
  assign C_out[1]        = if_d4.C_out;

  serial_adder_unit #(.WIDTH(W), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .bus(if_d1.slave), .dbg_state(dbg_d1)
  );
  serial_adder_unit #(.WIDTH(W), .DIGIT(4)) dut_d4 (
    .clk(clk), .rst(rst), .bus(if_d4.slave), .dbg_state(dbg_d4)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Plain arithmetic on the true sum; returns {carry, result}.
  function automatic logic [W:0] ref_calc(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] c);
    int s;
    case (op)
      OP_ADD:  s = int'(a) + int'(b);
      OP_SUB:  s = int'(a) + ((1 << W) - 1 - int'(b)) + 1;
      OP_ADD3: s = int'(a) + int'(b) + int'(c);
      default: s = int'(a) + int'(b) + int'(c[0]);
    endcase
    ref_calc = {(s >= (1 << W)), W'(s)};
  endfunction

  // Handshake-level expectation: an accepted op yields its result exactly
  // NS cycles later, held until taken; reset clears everything.
  bit           m_idle[2], m_valid[2], m_known[2];
  int           m_left[2];
  logic [W-1:0] m_r[2], m_pend_r[2];
  logic         m_c[2], m_pend_c[2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_idle[d] = 1; m_valid[d] = 0; m_left[d] = 0;
        m_r[d] = '0; m_c[d] = 1'b0; m_known[d] = 1;
      end else if (m_idle[d]) begin
        if (in_valid[d]) begin
          {m_pend_c[d], m_pend_r[d]} = ref_calc(opcode[d], A[d], B[d], C[d]);
          m_idle[d] = 0; m_known[d] = 0; m_left[d] = NS[d];
        end
      end else if (m_left[d] > 0) begin
        m_left[d]--;
        if (m_left[d] == 0) begin
          m_valid[d] = 1; m_known[d] = 1;
          m_r[d] = m_pend_r[d]; m_c[d] = m_pend_c[d];
        end
      end else if (m_valid[d] && out_ready[d]) begin
        m_valid[d] = 0; m_idle[d] = 1; m_known[d] = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("cyc%0d in_ready", d), int'(in_ready[d]), int'(m_idle[d]));
        check($sformatf("cyc%0d out_valid", d), int'(out_valid[d]), int'(m_valid[d]));
        if (m_known[d]) begin
          check($sformatf("cyc%0d R", d), int'(R[d]), int'(m_r[d]));
          check($sformatf("cyc%0d C_out", d), int'(C_out[d]), int'(m_c[d]));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge with the selected DUT idle. Offers one op, measures
  // edges from the accepting edge to out_valid, then stalls out_ready for
  // 'hold' cycles while offering junk operands that must be ignored.
  task automatic run_op(input int d, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] c, input int hold,
                        output logic [W-1:0] r, output logic co, output int lat);
    logic [W:0] exp;
    exp = ref_calc(op, a, b, c);
    A[d] = a; B[d] = b; C[d] = c; opcode[d] = op;
    in_valid[d] = 1'b1; out_ready[d] = 1'b0;
    @(negedge clk);
    in_valid[d] = 1'b0;
    lat = 0;
    while (!out_valid[d] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("op%0d out_valid reached", d), int'(out_valid[d]), 1);
    r = R[d]; co = C_out[d];
    for (int i = 0; i < hold; i++) begin
      in_valid[d] = 1'b1;
      A[d] = W'($urandom); B[d] = W'($urandom); C[d] = W'($urandom);
      opcode[d] = 2'($urandom_range(0, 3));
      @(negedge clk);
      check($sformatf("stall%0d R", d), int'(R[d]), int'(exp[W-1:0]));
      check($sformatf("stall%0d C_out", d), int'(C_out[d]), int'(exp[W]));
      check($sformatf("stall%0d in_ready", d), int'(in_ready[d]), 0);
    end
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    check($sformatf("after take%0d in_ready", d), int'(in_ready[d]), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] r;
    logic         co;
    int           lat;
    logic [W:0]   exp;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 0; out_ready[d] = 0; A[d] = 0; B[d] = 0; C[d] = 0; opcode[d] = 0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checking = 1;

    // Reset state
    check("reset in_ready", int'(in_ready[0]), 1);
    check("reset out_valid", int'(out_valid[0]), 0);
    check("reset R", int'(R[0]), 0);
    check("reset C_out", int'(C_out[0]), 0);
    check("reset state", int'(dbg_d1), int'(ST_IDLE));

    // Directed literal cases; the first one also stalls out_ready for 10 cycles
    run_op(0, OP_ADD, 8'd200, 8'd100, 8'd0, 10, r, co, lat);
    check("add R", int'(r), 44);
    check("add C_out", int'(co), 1);
    check("add latency", lat, 8);
    check("add back to idle", int'(dbg_d1), int'(ST_IDLE));

    run_op(0, OP_SUB, 8'd5, 8'd7, 8'd0, 0, r, co, lat);
    check("sub5-7 R", int'(r), 254);
    check("sub5-7 C_out", int'(co), 0);
    run_op(0, OP_SUB, 8'd7, 8'd5, 8'd0, 1, r, co, lat);
    check("sub7-5 R", int'(r), 2);
    check("sub7-5 C_out", int'(co), 1);

    run_op(0, OP_ADD3, 8'd255, 8'd255, 8'd255, 0, r, co, lat);
    check("add3 R", int'(r), 253);
    check("add3 C_out", int'(co), 1);
    run_op(0, OP_ADDC, 8'd255, 8'd0, 8'd1, 0, r, co, lat);
    check("addc R", int'(r), 0);
    check("addc C_out", int'(co), 1);

    run_op(1, OP_ADD, 8'd15, 8'd1, 8'd0, 2, r, co, lat);
    check("d4 add R", int'(r), 16);
    check("d4 add C_out", int'(co), 0);
    check("d4 add latency", lat, 2);

    // Reset in the third RUN cycle, with in_valid asserted alongside rst
    A[0] = 8'd10; B[0] = 8'd20; C[0] = 8'd0; opcode[0] = OP_ADD;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    in_valid[0] = 1'b1; A[0] = 8'd3; B[0] = 8'd4;
    @(negedge clk);
    rst = 1'b0;
    in_valid[0] = 1'b0;
    check("midrun rst out_valid", int'(out_valid[0]), 0);
    check("midrun rst R", int'(R[0]), 0);
    check("midrun rst C_out", int'(C_out[0]), 0);
    check("midrun rst in_ready", int'(in_ready[0]), 1);
    @(negedge clk);
    check("rst-cycle valid not taken", int'(in_ready[0]), 1);
    run_op(0, OP_ADD, 8'd90, 8'd80, 8'd0, 0, r, co, lat);
    check("post-rst R", int'(r), 170);
    check("post-rst C_out", int'(co), 0);

    // Randomized operations on both units
    for (int i = 0; i < 60; i++) begin
      int           d;
      logic [1:0]   op;
      logic [W-1:0] a, b, c;
      d  = i % 2;
      op = 2'($urandom_range(0, 3));
      a  = W'($urandom); b = W'($urandom); c = W'($urandom);
      if (i % 10 == 0) begin a = '1; b = '1; c = '1; end
      exp = ref_calc(op, a, b, c);
      run_op(d, op, a, b, c, $urandom_range(0, 3), r, co, lat);
      check($sformatf("rand%0d R", i), int'(r), int'(exp[W-1:0]));
      check($sformatf("rand%0d C_out", i), int'(co), int'(exp[W]));
      check($sformatf("rand%0d latency", i), lat, NS[d]);
    end

    checking = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
